// File: rtl/ram_ctrl.sv
// Request-side controller for the 32 x 32 single-port RAM: word reads and
// writes over valid/ready, held read response, and a sequential clear sweep.
module ram_ctrl #(
    parameter int RD_LAT     = 1,
    parameter bit CLR_ON_RST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    input  logic        clr_start,
    output logic        busy,
    output logic        ram_ena,
    output logic        ram_wena,
    output logic [4:0]  ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        RD_WAIT,
        RESP
    } state_t;

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT - 1);

    state_t      state, state_n;
    logic [4:0]  clr_cnt, clr_cnt_n;
    logic [1:0]  lat_cnt, lat_cnt_n;
    logic        ram_ena_n, ram_wena_n;
    logic [4:0]  ram_addr_n;
    logic [31:0] ram_wdata_n;
    logic        req_ready_n, rsp_valid_n, busy_n;
    logic [31:0] rsp_data_n;
    logic        accept;
    logic        clr_done;

    assign accept   = req_valid && req_ready;
    // The counter has wrapped back to 0 right after address 31 went out.
    assign clr_done = ram_wena && (clr_cnt == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLR_ON_RST ? CLEAR : IDLE;
            clr_cnt   <= 5'd0;
            lat_cnt   <= 2'd0;
            ram_ena   <= 1'b0;
            ram_wena  <= 1'b0;
            ram_addr  <= 5'd0;
            ram_wdata <= 32'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 32'd0;
            busy      <= CLR_ON_RST;
        end else begin
            state     <= state_n;
            clr_cnt   <= clr_cnt_n;
            lat_cnt   <= lat_cnt_n;
            ram_ena   <= ram_ena_n;
            ram_wena  <= ram_wena_n;
            ram_addr  <= ram_addr_n;
            ram_wdata <= ram_wdata_n;
            req_ready <= req_ready_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (clr_start)
                    state_n = CLEAR;
                else if (accept && !req_we)
                    state_n = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST)
                    state_n = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_n = IDLE;
            end
            CLEAR: begin
                if (clr_done)
                    state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        ram_ena_n   = 1'b0;
        ram_wena_n  = 1'b0;
        ram_addr_n  = ram_addr;
        ram_wdata_n = ram_wdata;
        req_ready_n = 1'b0;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        clr_cnt_n   = clr_cnt;
        lat_cnt_n   = lat_cnt;
        busy_n      = (state_n != IDLE);
        unique case (state)
            IDLE: begin
                req_ready_n = 1'b1;
                if (clr_start) begin
                    req_ready_n = 1'b0;
                    clr_cnt_n   = 5'd0;
                end else if (accept) begin
                    ram_ena_n  = 1'b1;
                    ram_wena_n = req_we;
                    ram_addr_n = req_addr;
                    if (req_we) begin
                        ram_wdata_n = req_wdata;
                    end else begin
                        req_ready_n = 1'b0;
                        lat_cnt_n   = 2'd0;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = ram_rdata;
                end else begin
                    ram_ena_n = 1'b1;
                    lat_cnt_n = lat_cnt + 2'd1;
                end
            end
            RESP: begin
                rsp_valid_n = 1'b1;
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    req_ready_n = 1'b1;
                end
            end
            CLEAR: begin
                if (clr_done) begin
                    req_ready_n = 1'b1;
                end else begin
                    ram_ena_n   = 1'b1;
                    ram_wena_n  = 1'b1;
                    ram_addr_n  = clr_cnt;
                    ram_wdata_n = 32'd0;
                    clr_cnt_n   = clr_cnt + 5'd1;
                end
            end
        endcase
    end

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Request-side controller for the 32 x 32-bit single-port `ram` block. It accepts word read and write requests over a valid/ready handshake and drives the RAM's `ena`/`wena`/`addr`/`data_in` port. It captures `data_out` into a held response, and can zero the whole array with a sequential clear sweep. It sits between any bus master or core datapath and the `ram` instance, which it owns exclusively.

## Interface
- `RD_LAT`, 1: cycles from the RAM read-enable edge to valid `ram_rdata`; legal values 1–3.
- `CLR_ON_RST`, 1: 1 = start a clear sweep automatically on reset release.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request this cycle.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 5: word address.
- `req_wdata` in 32: write data.
- `rsp_valid` out 1: read data valid; held until consumed.
- `rsp_ready` in 1: response consumer ready.
- `rsp_data` out 32: read data.
- `clr_start` in 1: request a clear sweep.
- `busy` out 1: high in every state except IDLE.
- `ram_ena` out 1: to `ram.ena`.
- `ram_wena` out 1: to `ram.wena`.
- `ram_addr` out 5: to `ram.addr`.
- `ram_wdata` out 32: to `ram.data_in`.
- `ram_rdata` in 32: from `ram.data_out`.

## Operation
- All `ram_*` outputs and all handshake outputs are registered.
- States: CLEAR, IDLE, RD_WAIT, RESP.
- Reset values:
  - State: CLEAR if `CLR_ON_RST`=1, else IDLE.
  - `ram_ena`=0, `ram_wena`=0, `ram_addr`=0, `ram_wdata`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_data`=0.
  - `busy`=`CLR_ON_RST`.
  - Clear counter=0.
- IDLE:
  - `req_ready`=1.
  - `clr_start`=1 takes priority over `req_valid`. The request is not accepted and `req_ready` drops the next cycle. The controller enters CLEAR.
  - Accepted write (`req_valid && req_ready && req_we`): the next cycle drives `ram_ena`=1, `ram_wena`=1, `ram_addr`=`req_addr`, `ram_wdata`=`req_wdata`. State stays IDLE and `req_ready` stays 1, so back-to-back writes run at 1 per cycle.
  - Accepted read: the next cycle drives `ram_ena`=1, `ram_wena`=0, `ram_addr`=`req_addr`. `req_ready` drops to 0 and the state goes to RD_WAIT.
  - With no accepted request, `ram_ena`=0 and `ram_wena`=0. `ram_addr` and `ram_wdata` hold their last values.
- RD_WAIT:
  - `ram_ena` is held 1 and `ram_wena` 0 for the full wait.
  - After `RD_LAT` cycles, `ram_rdata` is captured into `rsp_data` and the state goes to RESP.
- RESP:
  - `rsp_valid`=1 and `rsp_data` is stable until `rsp_valid && rsp_ready`.
  - On that handshake, `rsp_valid` goes to 0, `req_ready` goes to 1 and the state goes to IDLE, all in the same edge.
  - `rsp_ready` held high gives a one-cycle RESP.
- CLEAR:
  - A 5-bit counter runs 0..31 and drives `ram_ena`=1, `ram_wena`=1, `ram_wdata`=0, `ram_addr`=counter, one word per cycle.
  - After address 31 is written, the next cycle has `ram_ena`=0 and the state is IDLE.
  - `req_ready`=0 throughout CLEAR.
  - `clr_start` is ignored in every state other than IDLE.
- One operation is outstanding at a time. Writes never reorder past an outstanding read, because no request is accepted until the read response is consumed.

## Timing
- Write: accept at edge N → RAM port active during cycle N+1 → data committed at edge N+2.
- Read, `RD_LAT`=1: accept at edge N → `ram_ena` during N+1 → data captured at edge N+2 → `rsp_valid` high from N+2. Minimum request-to-request spacing for reads is 3 cycles.
- Clear sweep: 32 active cycles plus 1 exit cycle. `busy` falls one cycle after the final write.
- Reset mid-operation (CLEAR, RD_WAIT or RESP): at the next edge all outputs take their reset values. A pending response is discarded and the partial clear is abandoned. If `CLR_ON_RST`=1, the sweep restarts from address 0.
- Read of an address in the same cycle its write is on the RAM port: not possible, since accept-to-port is ordered and writes commit before any later read reaches the port.
- Address wrap: the clear counter wraps 31→0 only internally; the sweep terminates on 31.

## Test plan
- Reset with `CLR_ON_RST`=1 → 32 consecutive `ram_ena`/`wena` cycles, addr 0..31, data 0. Then `busy`=0 and `req_ready`=1. A subsequent read of addr 7 returns 0x00000000.
- Back-to-back writes: addr 1=0xA5A5A5A5, addr 2=0x5A5A5A5A, addr 3=0x12345678 on consecutive cycles → `req_ready` never drops; `ram_addr` sequence 1,2,3 on consecutive cycles.
- Reads of addr 1, 2, 3 with `rsp_ready`=1 → `rsp_data` 0xA5A5A5A5, 0x5A5A5A5A, 0x12345678. Each `rsp_valid` pulse lasts 1 cycle, spaced 3 cycles apart.
- Read of addr 0 after writing 0x77777777, with `rsp_ready` held low 5 cycles → `rsp_valid` and `rsp_data`=0x77777777 stable for 5 cycles, `req_ready`=0 throughout. The response is consumed on the first cycle `rsp_ready`=1.
- `clr_start` and a write of addr 4=0xDEADBEEF asserted in the same IDLE cycle → write not accepted, clear sweep runs. Re-issuing the write afterwards then reading addr 4 returns 0xDEADBEEF.
- `rst` pulsed in the middle of RESP and at clear address 15 → next cycle all outputs at reset values, `rsp_valid`=0, sweep restarts at address 0.
